route_computation: RTL and testbench



---
 rtl/params_noc.sv | 20 ++
 rtl/route_computation_if.sv | 31 +++
 rtl/route_compare.sv | 30 +++
 rtl/route_computation.sv | 70 +++++++
 tb/tb_route_computation.sv | 133 +++++++++++++
 5 files changed

// File: rtl/params_noc.sv
// params_noc: shared NoC definitions.
//   inout_Port   - router output port selector (LOCAL, NORTH, SOUTH, WEST, EAST)
//   MESH_X_DEF / MESH_Y_DEF           - default mesh dimensions
//   X_ADDR_W_DEF / Y_ADDR_W_DEF       - default destination field widths
package params_noc;

  typedef enum logic [2:0] {
    LOCAL,
    NORTH,
    SOUTH,
    WEST,
    EAST
  } inout_Port;

  localparam int MESH_X_DEF   = 16;
  localparam int MESH_Y_DEF   = 16;
  localparam int X_ADDR_W_DEF = 4;
  localparam int Y_ADDR_W_DEF = 4;

endpackage

// File: rtl/route_computation_if.sv
// route_computation_if: head-flit destination in, route decision out.
//   x_Dest, y_Dest, valid_i  - destination fields and qualifier (driven by master)
//   port                     - combinational route decision
//   port_q, valid_q, err_q   - registered decision, freshness, out-of-bounds flag
// Modports: master (input unit side), slave (route_computation).
interface route_computation_if
  import params_noc::*;
#(
  parameter int x_Des_Addr_Size = X_ADDR_W_DEF,
  parameter int y_Des_Addr_Size = Y_ADDR_W_DEF
);

  logic [x_Des_Addr_Size-1:0] x_Dest;
  logic [y_Des_Addr_Size-1:0] y_Dest;
  logic                       valid_i;
  inout_Port                  port;
  inout_Port                  port_q;
  logic                       valid_q;
  logic                       err_q;

  modport master (
    output x_Dest, y_Dest, valid_i,
    input  port, port_q, valid_q, err_q
  );

  modport slave (
    input  x_Dest, y_Dest, valid_i,
    output port, port_q, valid_q, err_q
  );

endinterface

// File: rtl/route_compare.sv
// route_compare: pure combinational XY (dimension-ordered) routing decision.
//   x_Dest, y_Dest - destination coordinates (unsigned)
//   port           - WEST/EAST while X differs, else NORTH/SOUTH while Y
//                    differs, else LOCAL. Y grows southward, X eastward.
module route_compare
  import params_noc::*;
#(
  parameter int x_Current       = 0,
  parameter int y_Current       = 0,
  parameter int x_Des_Addr_Size = X_ADDR_W_DEF,
  parameter int y_Des_Addr_Size = Y_ADDR_W_DEF
) (
  input  logic [x_Des_Addr_Size-1:0] x_Dest,
  input  logic [y_Des_Addr_Size-1:0] y_Dest,
  output inout_Port                  port
);

  localparam logic [x_Des_Addr_Size-1:0] X_CUR = x_Des_Addr_Size'(x_Current);
  localparam logic [y_Des_Addr_Size-1:0] Y_CUR = y_Des_Addr_Size'(y_Current);

  always_comb begin
    port = LOCAL;
    if (x_Dest < X_CUR)      port = WEST;
    else if (x_Dest > X_CUR) port = EAST;
    else if (y_Dest < Y_CUR) port = NORTH;
    else if (y_Dest > Y_CUR) port = SOUTH;
    else                     port = LOCAL;
  end

endmodule

// File: rtl/route_computation.sv
// route_computation: XY route computation for one 2D-mesh router input unit.
//   clk, rst - router clock, asynchronous active-high reset
//   rc       - route_computation_if.slave: x_Dest/y_Dest/valid_i in;
//              port (combinational), port_q/valid_q/err_q (registered) out
// Optional feature macro: RC_BOUND_CHECK_EN - flags destinations outside
// MESH_X x MESH_Y on err_q and forces port_q to LOCAL for them.
module route_computation
  import params_noc::*;
#(
  parameter int x_Current       = 0,
  parameter int y_Current       = 0,
  parameter int x_Des_Addr_Size = X_ADDR_W_DEF,
  parameter int y_Des_Addr_Size = Y_ADDR_W_DEF,
  parameter int MESH_X          = MESH_X_DEF,
  parameter int MESH_Y          = MESH_Y_DEF
) (
  input  logic                clk,
  input  logic                rst,
  route_computation_if.slave  rc
);

  // The router must sit inside its own mesh.
  if (x_Current < 0 || x_Current >= MESH_X ||
      y_Current < 0 || y_Current >= MESH_Y) begin : g_bad_coord
    $error("route_computation: router coordinate outside mesh");
  end

  inout_Port route;
  logic      out_of_bounds;

  route_compare #(
    .x_Current       (x_Current),
    .y_Current       (y_Current),
    .x_Des_Addr_Size (x_Des_Addr_Size),
    .y_Des_Addr_Size (y_Des_Addr_Size)
  ) u_route_compare (
    .x_Dest (rc.x_Dest),
    .y_Dest (rc.y_Dest),
    .port   (route)
  );

  assign rc.port = route;

`ifdef RC_BOUND_CHECK_EN
  localparam int unsigned MX = MESH_X;
  localparam int unsigned MY = MESH_Y;

  // Compare in 32 bits so a mesh larger than the field range never wraps.
  assign out_of_bounds = (32'(rc.x_Dest) >= MX) || (32'(rc.y_Dest) >= MY);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)             rc.err_q <= 1'b0;
    else if (rc.valid_i) rc.err_q <= out_of_bounds;
  end
`else
  assign out_of_bounds = 1'b0;
  assign rc.err_q      = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rc.port_q  <= LOCAL;
      rc.valid_q <= 1'b0;
    end else begin
      rc.valid_q <= rc.valid_i;
      if (rc.valid_i) rc.port_q <= out_of_bounds ? LOCAL : route;
    end
  end

endmodule

// File: tb/tb_route_computation.sv
// tb_route_computation: directed bench for route_computation at (3,3),
// 5-bit destination fields, MESH_X=8, MESH_Y=16.
module tb_route_computation;
  import params_noc::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  route_computation_if #(.x_Des_Addr_Size(5), .y_Des_Addr_Size(5)) rc_if ();

  route_computation #(
    .x_Current       (3),
    .y_Current       (3),
    .x_Des_Addr_Size (5),
    .y_Des_Addr_Size (5),
    .MESH_X          (8),
    .MESH_Y          (16)
  ) dut (
    .clk (clk),
    .rst (rst),
    .rc  (rc_if.slave)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Drive a destination at the falling edge and check the combinational port.
  task automatic comb_vec(input string tag, input logic [4:0] x, input logic [4:0] y,
                          input inout_Port exp);
    @(negedge clk);
    rc_if.x_Dest = x;
    rc_if.y_Dest = y;
    #1;
    chk(tag, 32'(rc_if.port), 32'(exp));
  endtask

  // Present a destination with valid_i for one edge, sample 1 unit after it.
  task automatic reg_vec(input logic v, input logic [4:0] x, input logic [4:0] y);
    @(negedge clk);
    rc_if.valid_i = v;
    rc_if.x_Dest  = x;
    rc_if.y_Dest  = y;
    @(posedge clk);
    #1;
  endtask

  logic [4:0] sw_x [8];
  logic [4:0] sw_y [8];
  inout_Port  sw_p [8];

  initial begin
    rc_if.x_Dest  = '0;
    rc_if.y_Dest  = '0;
    rc_if.valid_i = 1'b0;

    // Reset state
    #12;
    chk("rst_port_q",  32'(rc_if.port_q), 32'(LOCAL));
    chk("rst_valid_q", 32'(rc_if.valid_q), 32'd0);
    chk("rst_err_q",   32'(rc_if.err_q),  32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Sweep from (0,0): X toward 3 with Y=0, then Y toward 3 with X=3
    sw_x = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd3, 5'd3, 5'd3, 5'd3};
    sw_y = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd1, 5'd2, 5'd3};
    sw_p = '{WEST, WEST, WEST, NORTH, NORTH, NORTH, NORTH, LOCAL};
    for (int i = 0; i < 8; i++) comb_vec($sformatf("sweep%0d", i), sw_x[i], sw_y[i], sw_p[i]);

    // Directed points and field boundaries
    comb_vec("d7_1_east",   5'd7,  5'd1,  EAST);
    comb_vec("d3_9_south",  5'd3,  5'd9,  SOUTH);
    comb_vec("d2_9_west",   5'd2,  5'd9,  WEST);
    comb_vec("d31_31_east", 5'd31, 5'd31, EAST);
    comb_vec("d3_31_south", 5'd3,  5'd31, SOUTH);
    comb_vec("d0_31_west",  5'd0,  5'd31, WEST);
    comb_vec("d4_0_east",   5'd4,  5'd0,  EAST);

    // Registered path: capture, then hold when valid_i drops
    reg_vec(1'b1, 5'd5, 5'd3);
    chk("reg_port_q_east", 32'(rc_if.port_q), 32'(EAST));
    chk("reg_valid_q_1",   32'(rc_if.valid_q), 32'd1);
    reg_vec(1'b0, 5'd0, 5'd0);
    chk("hold_valid_q_0",  32'(rc_if.valid_q), 32'd0);
    chk("hold_port_q",     32'(rc_if.port_q), 32'(EAST));

    // Back-to-back decisions
    reg_vec(1'b1, 5'd3, 5'd1);
    chk("b2b0_port_q",  32'(rc_if.port_q), 32'(NORTH));
    reg_vec(1'b1, 5'd1, 5'd7);
    chk("b2b1_port_q",  32'(rc_if.port_q), 32'(WEST));
    chk("b2b1_valid_q", 32'(rc_if.valid_q), 32'd1);

    // Asynchronous reset mid-cycle while valid_q=1
    #2;
    rst = 1'b1;
    #1;
    chk("arst_port_q",  32'(rc_if.port_q), 32'(LOCAL));
    chk("arst_valid_q", 32'(rc_if.valid_q), 32'd0);
    chk("arst_port",    32'(rc_if.port), 32'(WEST));
    @(negedge clk);
    rst = 1'b0;

    // Out-of-mesh destination (31,0) with MESH_X=8
    reg_vec(1'b1, 5'd31, 5'd0);
`ifdef RC_BOUND_CHECK_EN
    chk("oob_err_q",  32'(rc_if.err_q),  32'd1);
    chk("oob_port_q", 32'(rc_if.port_q), 32'(LOCAL));
`else
    chk("oob_err_q",  32'(rc_if.err_q),  32'd0);
    chk("oob_port_q", 32'(rc_if.port_q), 32'(EAST));
`endif
    chk("oob_port", 32'(rc_if.port), 32'(EAST));

    // In-range destination afterwards clears any error
    reg_vec(1'b1, 5'd3, 5'd3);
    chk("inr_err_q",  32'(rc_if.err_q),  32'd0);
    chk("inr_port_q", 32'(rc_if.port_q), 32'(LOCAL));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
